// File: rtl/ccip_tracker_pkg.sv
// Shared types and default sizing for the CCI-P C0 read tag tracker.
// Optional latency statistics are enabled with CCIP_TRACKER_LAT_STATS_EN.
package ccip_tracker_pkg;

  localparam int TRK_TAG_W   = 6;
  localparam int TRK_CNT_W   = 16;
  localparam int TRK_TIMEOUT = 4096;
  localparam int DEPTH       = 2 ** TRK_TAG_W;

  typedef logic [TRK_TAG_W-1:0] tag_t;
  typedef logic [TRK_CNT_W-1:0] age_t;

  typedef struct packed {
    logic valid;
    age_t age;
  } trk_entry_t;

  typedef enum logic [1:0] {
    ERR_NONE,
    ERR_DUP,
    ERR_ORPHAN,
    ERR_TIMEOUT
  } err_code_e;

endpackage

// File: rtl/ccip_tracker_entry.sv
// One tracker slot: valid flag plus saturating age, flagged expired once age reaches TIMEOUT.
module ccip_tracker_entry
  import ccip_tracker_pkg::*;
#(
  parameter int CNT_W   = TRK_CNT_W,
  parameter int TIMEOUT = TRK_TIMEOUT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             alloc,
  input  logic             retire,
  input  logic             tmo_clr,
  output logic             valid,
  output logic [CNT_W-1:0] age,
  output logic             expired
);

  localparam logic [CNT_W-1:0] AGE_MAX = '1;
  localparam logic [CNT_W-1:0] TMO_AGE = CNT_W'(TIMEOUT);

  logic             r_valid;
  logic [CNT_W-1:0] r_age;

  // Allocate wins over retire so a same-cycle retire+allocate re-arms the slot at age 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid <= 1'b0;
      r_age   <= '0;
    end else if (alloc) begin
      r_valid <= 1'b1;
      r_age   <= '0;
    end else if (retire || tmo_clr) begin
      r_valid <= 1'b0;
      r_age   <= '0;
    end else if (r_valid && (r_age != AGE_MAX)) begin
      r_age <= r_age + 1'b1;
    end
  end

  assign valid   = r_valid;
  assign age     = r_age;
  assign expired = r_valid && (r_age >= TMO_AGE);

endmodule

// File: rtl/ccip_rd_tag_tracker.sv
// Tracks outstanding C0 read tags, pulsing dup/orphan/timeout errors one cycle after the cause.
// Define CCIP_TRACKER_LAT_STATS_EN to add min/max request-to-response latency outputs.
module ccip_rd_tag_tracker
  import ccip_tracker_pkg::*;
#(
  parameter int TAG_W   = TRK_TAG_W,
  parameter int CNT_W   = TRK_CNT_W,
  parameter int TIMEOUT = TRK_TIMEOUT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req_valid,
  input  logic [TAG_W-1:0] req_tag,
  input  logic             rsp_valid,
  input  logic [TAG_W-1:0] rsp_tag,
  output logic             err_dup_tag,
  output logic             err_orphan_rsp,
  output logic             err_timeout,
  output logic [TAG_W-1:0] err_tag,
  output logic             err_sticky,
  output logic [TAG_W:0]   outstanding_cnt,
`ifdef CCIP_TRACKER_LAT_STATS_EN
  output logic [CNT_W-1:0] lat_min,
  output logic [CNT_W-1:0] lat_max,
  output logic             lat_valid,
`endif
  output logic             idle
);

  localparam int N_ENT = 1 << TAG_W;
  localparam int OCC_W = TAG_W + 1;

  logic [N_ENT-1:0]            w_valid;
  logic [N_ENT-1:0]            w_expired;
  logic [N_ENT-1:0]            w_alloc;
  logic [N_ENT-1:0]            w_retire;
  logic [N_ENT-1:0]            w_tmo_clr;
  logic [N_ENT-1:0][CNT_W-1:0] w_age;

  logic             w_same_tag;
  logic             w_dup;
  logic             w_orphan;
  logic             w_do_alloc;
  logic             w_do_retire;
  logic             w_tmo;
  err_code_e        w_err_code;
  logic [TAG_W-1:0] w_err_tag;
  logic [OCC_W-1:0] w_cnt_next;

  logic [TAG_W-1:0] r_scan_ptr;
  logic             r_err_dup;
  logic             r_err_orphan;
  logic             r_err_timeout;
  logic [TAG_W-1:0] r_err_tag;
  logic             r_err_sticky;
  logic [OCC_W-1:0] r_cnt;
  logic             r_idle;

  // A response on the requested tag retires it first, so the request is not a duplicate.
  assign w_same_tag  = req_valid && rsp_valid && (req_tag == rsp_tag);
  assign w_do_retire = rsp_valid && w_valid[rsp_tag];
  assign w_orphan    = rsp_valid && !w_valid[rsp_tag];
  assign w_dup       = req_valid && w_valid[req_tag] && !w_same_tag;
  assign w_do_alloc  = req_valid && !w_dup;
  assign w_tmo       = w_expired[r_scan_ptr]
                       && !(req_valid && (req_tag == r_scan_ptr))
                       && !(rsp_valid && (rsp_tag == r_scan_ptr));

  generate
    for (genvar gi = 0; gi < N_ENT; gi++) begin : g_ent
      assign w_alloc[gi]   = w_do_alloc  && (req_tag == TAG_W'(gi));
      assign w_retire[gi]  = w_do_retire && (rsp_tag == TAG_W'(gi));
      assign w_tmo_clr[gi] = w_tmo       && (r_scan_ptr == TAG_W'(gi));

      ccip_tracker_entry #(
        .CNT_W   (CNT_W),
        .TIMEOUT (TIMEOUT)
      ) u_entry (
        .clk     (clk),
        .rst_n   (rst_n),
        .alloc   (w_alloc[gi]),
        .retire  (w_retire[gi]),
        .tmo_clr (w_tmo_clr[gi]),
        .valid   (w_valid[gi]),
        .age     (w_age[gi]),
        .expired (w_expired[gi])
      );
    end
  endgenerate

  always_comb begin
    w_err_code = ERR_NONE;
    if (w_dup) begin
      w_err_code = ERR_DUP;
    end else if (w_orphan) begin
      w_err_code = ERR_ORPHAN;
    end else if (w_tmo) begin
      w_err_code = ERR_TIMEOUT;
    end
  end

  always_comb begin
    w_err_tag = '0;
    case (w_err_code)
      ERR_DUP:     w_err_tag = req_tag;
      ERR_ORPHAN:  w_err_tag = rsp_tag;
      ERR_TIMEOUT: w_err_tag = r_scan_ptr;
      default:     w_err_tag = '0;
    endcase
  end

  // At most one allocate, one retire and one timeout clear per cycle: net change in [-2, +1].
  assign w_cnt_next = r_cnt + OCC_W'(w_do_alloc) - OCC_W'(w_do_retire) - OCC_W'(w_tmo);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_scan_ptr    <= '0;
      r_err_dup     <= 1'b0;
      r_err_orphan  <= 1'b0;
      r_err_timeout <= 1'b0;
      r_err_tag     <= '0;
      r_err_sticky  <= 1'b0;
      r_cnt         <= '0;
      r_idle        <= 1'b1;
    end else begin
      r_scan_ptr    <= r_scan_ptr + 1'b1;
      r_err_dup     <= w_dup;
      r_err_orphan  <= w_orphan;
      r_err_timeout <= w_tmo;
      r_err_tag     <= w_err_tag;
      r_err_sticky  <= r_err_sticky | w_dup | w_orphan | w_tmo;
      r_cnt         <= w_cnt_next;
      r_idle        <= (w_cnt_next == '0);
    end
  end

  assign err_dup_tag     = r_err_dup;
  assign err_orphan_rsp  = r_err_orphan;
  assign err_timeout     = r_err_timeout;
  assign err_tag         = r_err_tag;
  assign err_sticky      = r_err_sticky;
  assign outstanding_cnt = r_cnt;
  assign idle            = r_idle;

`ifdef CCIP_TRACKER_LAT_STATS_EN
  logic [CNT_W-1:0] w_lat_sample;
  logic [CNT_W-1:0] r_lat_min;
  logic [CNT_W-1:0] r_lat_max;
  logic             r_lat_valid;

  assign w_lat_sample = (w_age[rsp_tag] == '1) ? '1 : (w_age[rsp_tag] + 1'b1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_lat_min   <= '1;
      r_lat_max   <= '0;
      r_lat_valid <= 1'b0;
    end else if (w_do_retire) begin
      r_lat_valid <= 1'b1;
      if (w_lat_sample < r_lat_min) begin
        r_lat_min <= w_lat_sample;
      end
      if (w_lat_sample > r_lat_max) begin
        r_lat_max <= w_lat_sample;
      end
    end
  end

  assign lat_min   = r_lat_min;
  assign lat_max   = r_lat_max;
  assign lat_valid = r_lat_valid;
`else
  logic w_unused_age;
  assign w_unused_age = ^w_age;
`endif

endmodule

// File: tb/tb_ccip_rd_tag_tracker.sv
// Directed self-checking bench for ccip_rd_tag_tracker, built with TIMEOUT = 100.
module tb_ccip_rd_tag_tracker;

  localparam int TAG_W = 6;
  localparam int CNT_W = 16;
  localparam int TMO   = 100;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             req_valid = 1'b0;
  logic [TAG_W-1:0] req_tag = '0;
  logic             rsp_valid = 1'b0;
  logic [TAG_W-1:0] rsp_tag = '0;
  logic             err_dup_tag;
  logic             err_orphan_rsp;
  logic             err_timeout;
  logic [TAG_W-1:0] err_tag;
  logic             err_sticky;
  logic [TAG_W:0]   outstanding_cnt;
  logic             idle;
`ifdef CCIP_TRACKER_LAT_STATS_EN
  logic [CNT_W-1:0] lat_min;
  logic [CNT_W-1:0] lat_max;
  logic             lat_valid;
`endif

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  ccip_rd_tag_tracker #(
    .TAG_W   (TAG_W),
    .CNT_W   (CNT_W),
    .TIMEOUT (TMO)
  ) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .req_valid       (req_valid),
    .req_tag         (req_tag),
    .rsp_valid       (rsp_valid),
    .rsp_tag         (rsp_tag),
    .err_dup_tag     (err_dup_tag),
    .err_orphan_rsp  (err_orphan_rsp),
    .err_timeout     (err_timeout),
    .err_tag         (err_tag),
    .err_sticky      (err_sticky),
    .outstanding_cnt (outstanding_cnt),
`ifdef CCIP_TRACKER_LAT_STATS_EN
    .lat_min         (lat_min),
    .lat_max         (lat_max),
    .lat_valid       (lat_valid),
`endif
    .idle            (idle)
  );

  task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", name, obs, exp);
    end
  endtask

  // One transaction per clock; outputs are sampled 1 time unit after the edge.
  task automatic step(input logic rv, input logic [TAG_W-1:0] rt,
                      input logic sv, input logic [TAG_W-1:0] st);
    req_valid = rv;
    req_tag   = rt;
    rsp_valid = sv;
    rsp_tag   = st;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    rsp_valid = 1'b0;
    $display("txn t=%0t req=%0b/%0d rsp=%0b/%0d -> dup=%0b orph=%0b tmo=%0b tag=%0d cnt=%0d",
             $time, rv, rt, sv, st, err_dup_tag, err_orphan_rsp, err_timeout, err_tag,
             outstanding_cnt);
  endtask

  task automatic idle_n(input int n);
    for (int i = 0; i < n; i++) step(1'b0, '0, 1'b0, '0);
  endtask

  task automatic chk_no_err(input string name);
    chk({name, "_dup"}, err_dup_tag, 0);
    chk({name, "_orph"}, err_orphan_rsp, 0);
    chk({name, "_tmo"}, err_timeout, 0);
  endtask

  task automatic chk_reset_outputs(input string name);
    chk_no_err(name);
    chk({name, "_tag"}, err_tag, 0);
    chk({name, "_sticky"}, err_sticky, 0);
    chk({name, "_cnt"}, outstanding_cnt, 0);
    chk({name, "_idle"}, idle, 1);
`ifdef CCIP_TRACKER_LAT_STATS_EN
    chk({name, "_lmin"}, lat_min, 32'hFFFF);
    chk({name, "_lmax"}, lat_max, 0);
    chk({name, "_lvld"}, lat_valid, 0);
`endif
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int  n;
    bit  seen;

    #12;
    chk_reset_outputs("rst");
    @(negedge clk);
    rst_n = 1'b1;

    // Request then response 11 cycles later: latency sample 11.
    step(1'b1, 6'd5, 1'b0, '0);
    chk("t1_cnt1", outstanding_cnt, 1);
    chk("t1_idle0", idle, 0);
    chk_no_err("t1_req");
    idle_n(10);
    step(1'b0, '0, 1'b1, 6'd5);
    chk("t1_cnt0", outstanding_cnt, 0);
    chk("t1_idle1", idle, 1);
    chk_no_err("t1_rsp");
    chk("t1_sticky", err_sticky, 0);
`ifdef CCIP_TRACKER_LAT_STATS_EN
    chk("t1_lmin", lat_min, 11);
    chk("t1_lmax", lat_max, 11);
    chk("t1_lvld", lat_valid, 1);
`endif

    // Duplicate issue on tag 3.
    step(1'b1, 6'd3, 1'b0, '0);
    chk("t2_cnt1", outstanding_cnt, 1);
    step(1'b1, 6'd3, 1'b0, '0);
    chk("t2_dup", err_dup_tag, 1);
    chk("t2_tag", err_tag, 3);
    chk("t2_cnt", outstanding_cnt, 1);
    chk("t2_sticky", err_sticky, 1);
    step(1'b0, '0, 1'b0, '0);
    chk("t2_pulse", err_dup_tag, 0);
    step(1'b0, '0, 1'b1, 6'd3);
    chk("t2_clean_cnt", outstanding_cnt, 0);
    chk_no_err("t2_clean");

    // Orphan response on tag 9.
    step(1'b0, '0, 1'b1, 6'd9);
    chk("t3_orph", err_orphan_rsp, 1);
    chk("t3_tag", err_tag, 9);
    chk("t3_cnt", outstanding_cnt, 0);
    step(1'b0, '0, 1'b0, '0);
    chk("t3_pulse", err_orphan_rsp, 0);

    // Same-cycle retire and re-allocate on tag 7.
    step(1'b1, 6'd7, 1'b0, '0);
    idle_n(3);
    step(1'b1, 6'd7, 1'b1, 6'd7);
    chk_no_err("t5_same");
    chk("t5_cnt", outstanding_cnt, 1);
    step(1'b0, '0, 1'b1, 6'd7);
    chk_no_err("t5_rsp");
    chk("t5_cnt0", outstanding_cnt, 0);
`ifdef CCIP_TRACKER_LAT_STATS_EN
    chk("t5_lmin", lat_min, 1);
    chk("t5_lmax", lat_max, 11);
`endif

    // Timeout on tag 0: age hits 100 after 100 idle cycles, then at most 64 cycles of scan.
    step(1'b1, 6'd0, 1'b0, '0);
    chk("t4_cnt1", outstanding_cnt, 1);
    n    = 0;
    seen = 1'b0;
    for (int i = 1; i <= TMO + 64 + 6 && !seen; i++) begin
      step(1'b0, '0, 1'b0, '0);
      if (err_timeout) begin
        seen = 1'b1;
        n    = i;
      end
    end
    chk("t4_seen", seen, 1);
    chk("t4_not_early", n >= TMO + 1, 1);
    chk("t4_not_late", n <= TMO + 64 + 1, 1);
    chk("t4_tag", err_tag, 0);
    chk("t4_cnt0", outstanding_cnt, 0);
    chk("t4_idle", idle, 1);
    step(1'b0, '0, 1'b0, '0);
    chk("t4_pulse", err_timeout, 0);

    // Fill the table, then reset asynchronously mid-stream.
    for (int i = 0; i < 64; i++) step(1'b1, TAG_W'(i), 1'b0, '0);
    chk("t6_full", outstanding_cnt, 64);
    chk("t6_idle0", idle, 0);
    chk_no_err("t6_fill");
    req_valid = 1'b1;
    req_tag   = 6'd5;
    rsp_valid = 1'b1;
    rsp_tag   = 6'd10;
    #2;
    rst_n = 1'b0;
    #1;
    chk_reset_outputs("t6_rst");
    req_valid = 1'b0;
    rsp_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    step(1'b0, '0, 1'b1, 6'd0);
    chk("t6_orph", err_orphan_rsp, 1);
    chk("t6_tag", err_tag, 0);
    chk("t6_cnt", outstanding_cnt, 0);

    // Dup and orphan together: both pulse, dup wins err_tag.
    step(1'b1, 6'd2, 1'b0, '0);
    step(1'b1, 6'd2, 1'b1, 6'd20);
    chk("t7_dup", err_dup_tag, 1);
    chk("t7_orph", err_orphan_rsp, 1);
    chk("t7_tag", err_tag, 2);
    chk("t7_cnt", outstanding_cnt, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
